// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with IDLE/COUNT/DONE FSM, terminal-count level flag and pulse.
// Optional macro AUTO_RELOAD_EN: terminal count reloads the last loaded value instead of stopping.
module flex_down_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    load,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   input  logic                    count_enable,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    zero_flag,
   output logic                    done_pulse,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   state_t                    state, state_nxt;
   logic [NUM_CNT_BITS-1:0]   count_nxt;
   logic [NUM_CNT_BITS-1:0]   reload_reg, reload_nxt;
   logic                      pulse_nxt;

   // NOTE: every next-value signal gets a default before any branch, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count_out;
      reload_nxt = reload_reg;
      pulse_nxt  = 1'b0;

      if (clear) begin
         state_nxt  = IDLE;
         count_nxt  = CNT_ZERO;
         reload_nxt = CNT_ZERO;
      end else if (load) begin
         count_nxt  = load_val;
         reload_nxt = load_val;
         if (load_val != CNT_ZERO) begin
            state_nxt = COUNT;
         end else begin
            state_nxt = DONE;
            pulse_nxt = 1'b1;
         end
      end else begin
         unique case (state)
            COUNT: begin
               if (count_enable) begin
                  if (count_out > CNT_ONE) begin
                     count_nxt = count_out - CNT_ONE;
                  end else begin
                     // Terminal event; a count of 0 never survives in COUNT, so <=1 is safe.
                     pulse_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                     count_nxt = reload_reg;
                     state_nxt = COUNT;
`else
                     count_nxt = CNT_ZERO;
                     state_nxt = DONE;
`endif
                  end
               end
            end
            DONE: begin
               count_nxt = CNT_ZERO;
            end
            default: begin
               // IDLE holds the count and ignores count_enable.
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers
   // sample their next values from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         count_out  <= CNT_ZERO;
         reload_reg <= CNT_ZERO;
         zero_flag  <= 1'b0;
         done_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         count_out  <= count_nxt;
         reload_reg <= reload_nxt;
         zero_flag  <= (state_nxt == DONE);
         done_pulse <= pulse_nxt;
         busy       <= (state_nxt == COUNT);
      end
   end

endmodule

// File: tb/tb_flex_down_counter.sv
// Scoreboard bench for flex_down_counter: stimulus pushes expected outputs, a monitor pops and compares.
// Terminal-count vectors follow the one-shot build unless AUTO_RELOAD_EN is defined.
module tb_flex_down_counter;

   localparam int N = 4;

   typedef struct packed {
      logic [N-1:0] cnt;
      logic         zf;
      logic         dp;
      logic         busy;
   } obs_t;

   typedef struct {
      string name;
      obs_t  exp;
   } sb_entry_t;

   logic         tb_clk = 1'b0;
   logic         n_rst;
   logic         clear, load, count_enable;
   logic [N-1:0] load_val;
   logic [N-1:0] count_out;
   logic         zero_flag, done_pulse, busy;

   int unsigned  vectors = 0;
   int unsigned  miscompares = 0;
   sb_entry_t    sb_q[$];
   sb_entry_t    mon_e;

   flex_down_counter #(.NUM_CNT_BITS(N)) dut (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .load         (load),
      .load_val     (load_val),
      .count_enable (count_enable),
      .count_out    (count_out),
      .zero_flag    (zero_flag),
      .done_pulse   (done_pulse),
      .busy         (busy)
   );

   always #5 tb_clk = ~tb_clk;

   function automatic obs_t observed();
      return '{cnt: count_out, zf: zero_flag, dp: done_pulse, busy: busy};
   endfunction

   function automatic void check(string name, obs_t act, obs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got cnt=%0d zf=%b dp=%b busy=%b, expected cnt=%0d zf=%b dp=%b busy=%b",
                  name, act.cnt, act.zf, act.dp, act.busy, exp.cnt, exp.zf, exp.dp, exp.busy);
      end
   endfunction

   // Monitor: outputs settle after each rising edge; compare the oldest pending expectation.
   always @(posedge tb_clk) begin
      #2;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check(mon_e.name, observed(), mon_e.exp);
      end
   end

   task automatic step(input string name, input logic c, input logic l, input int v,
                       input logic e, input int ecnt, input logic ezf, input logic edp,
                       input logic ebusy);
      sb_entry_t ent;
      @(negedge tb_clk);
      clear        = c;
      load         = l;
      load_val     = N'(v);
      count_enable = e;
      ent.name     = name;
      ent.exp      = '{cnt: N'(ecnt), zf: ezf, dp: edp, busy: ebusy};
      sb_q.push_back(ent);
   endtask

   task automatic drain();
      int budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
         @(posedge tb_clk);
         budget--;
      end
      #3;
      if (sb_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expectations never checked, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; count_enable = 1'b0;
      repeat (2) @(negedge tb_clk);
      check("por_reset", observed(), '0);
      n_rst = 1'b1;
      step("after_por", 0, 0, 0, 0, 0, 0, 0, 0);

`ifndef AUTO_RELOAD_EN
      // Five-step countdown to terminal count
      step("t2_load5", 0, 1, 5, 0, 5, 0, 0, 1);
      step("t2_en4",   0, 0, 0, 1, 4, 0, 0, 1);
      step("t2_en3",   0, 0, 0, 1, 3, 0, 0, 1);
      step("t2_en2",   0, 0, 0, 1, 2, 0, 0, 1);
      step("t2_en1",   0, 0, 0, 1, 1, 0, 0, 1);
      step("t2_en0",   0, 0, 0, 1, 0, 1, 1, 0);
      step("t2_pulse_drop", 0, 0, 0, 0, 0, 1, 0, 0);
      step("t2_done_hold",  0, 0, 0, 1, 0, 1, 0, 0);
`endif

      // Discontinuous counting
      step("t3_load4", 0, 1, 4, 0, 4, 0, 0, 1);
      step("t3_en3",   0, 0, 0, 1, 3, 0, 0, 1);
      step("t3_en2",   0, 0, 0, 1, 2, 0, 0, 1);
      step("t3_idle1", 0, 0, 0, 0, 2, 0, 0, 1);
      step("t3_idle2", 0, 0, 0, 0, 2, 0, 0, 1);
      step("t3_en1",   0, 0, 0, 1, 1, 0, 0, 1);

      // Control priority
      step("t4_load3",      0, 1, 3, 0, 3, 0, 0, 1);
      step("t4_clr_all",    1, 1, 9, 1, 0, 0, 0, 0);
      step("t4_idle_en",    0, 0, 0, 1, 0, 0, 0, 0);
      step("t4_load7_en",   0, 1, 7, 1, 7, 0, 0, 1);
      step("t4_en6",        0, 0, 0, 1, 6, 0, 0, 1);
      step("t4_reload_cnt", 0, 1, 2, 1, 2, 0, 0, 1);

      // Zero load and full-range countdown
      step("t5_load0",      0, 1, 0, 0, 0, 1, 1, 0);
      step("t5_load0_hold", 0, 0, 0, 1, 0, 1, 0, 0);
`ifndef AUTO_RELOAD_EN
      step("t5_load15", 0, 1, 15, 0, 15, 0, 0, 1);
      for (int i = 14; i >= 1; i--) step($sformatf("t5_en%0d", i), 0, 0, 0, 1, i, 0, 0, 1);
      step("t5_en0",        0, 0, 0, 1, 0, 1, 1, 0);
      step("t5_no_wrap_a",  0, 0, 0, 1, 0, 1, 0, 0);
      step("t5_no_wrap_b",  0, 0, 0, 1, 0, 1, 0, 0);
`else
      // Auto-reload: wraps back to the loaded value with a pulse each time
      step("t6_load3", 0, 1, 3, 0, 3, 0, 0, 1);
      step("t6_en2a",  0, 0, 0, 1, 2, 0, 0, 1);
      step("t6_en1a",  0, 0, 0, 1, 1, 0, 0, 1);
      step("t6_rl_a",  0, 0, 0, 1, 3, 0, 1, 1);
      step("t6_en2b",  0, 0, 0, 1, 2, 0, 0, 1);
      step("t6_en1b",  0, 0, 0, 1, 1, 0, 0, 1);
      step("t6_rl_b",  0, 0, 0, 1, 3, 0, 1, 1);
      step("t6_hold",  0, 0, 0, 0, 3, 0, 0, 1);
      step("t6_load0", 0, 1, 0, 0, 0, 1, 1, 0);
`endif

      // Asynchronous reset in the middle of a countdown
      step("t1_load5", 0, 1, 5, 0, 5, 0, 0, 1);
      step("t1_en4",   0, 0, 0, 1, 4, 0, 0, 1);
      drain();
      @(posedge tb_clk);
      #3;
      n_rst = 1'b0;
      #1;
      check("t1_async_now", observed(), '0);
      step("t1_rst_hold_a", 0, 1, 9, 1, 0, 0, 0, 0);
      step("t1_rst_hold_b", 0, 0, 0, 1, 0, 0, 0, 0);
      drain();
      @(negedge tb_clk);
      n_rst = 1'b1;
      #1;
      check("t1_release", observed(), '0);
      step("t1_post_idle", 0, 0, 0, 1, 0, 0, 0, 0);
      step("t1_post_en",   0, 0, 0, 1, 0, 0, 0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
